// File: rtl/aib_bringup_pkg.sv
// Shared types and sizing helpers for the AIB channel bring-up sequencer.
package aib_bringup_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_CONF = 4'd1,
    ST_RST_REL   = 4'd2,
    ST_TX_LOCK   = 4'd3,
    ST_RX_LOCK   = 4'd4,
    ST_ALIGN     = 4'd5,
    ST_NEXT      = 4'd6,
    ST_DONE      = 4'd7,
    ST_FAIL      = 4'd8
  } bringup_state_e;

  localparam int unsigned TIMEOUT_CYC_DFLT = 4096;
  localparam int unsigned TMR_W            = $clog2(TIMEOUT_CYC_DFLT + 1);

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aib_bringup_timer.sv
// Loadable down-counter; expired when the count has reached zero and no load is pending.
module aib_bringup_timer #(
  parameter int unsigned W = 13
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == '0) && !i_load;

endmodule

// File: rtl/aib_chnl_bringup_seq.sv
// Serial per-channel AIB bring-up sequencer with timeout/retry.
// Define AIB_BRINGUP_DBG_EN to add o_retry_total and o_state debug ports.
module aib_chnl_bringup_seq
  import aib_bringup_pkg::*;
#(
  parameter int unsigned TOTAL_CHNL_NUM  = 24,
  parameter int unsigned ACTIVE_CHNL_NUM = 24,
  parameter int unsigned RST_SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC     = 4096,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                                 i_osc_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic                                 i_conf_done,
  input  logic                                 i_por,
  output logic [TOTAL_CHNL_NUM-1:0]            o_ns_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0]            o_tx_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0]            o_rx_lock_req,
  input  logic [TOTAL_CHNL_NUM-1:0]            i_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0]            i_rx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0]            i_rx_align_done,
  output logic [TOTAL_CHNL_NUM-1:0]            o_ns_mac_rdy,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_fail,
  output logic [idx_w(TOTAL_CHNL_NUM)-1:0]     o_fail_chnl,
  output logic                                 o_link_lost
`ifdef AIB_BRINGUP_DBG_EN
  ,
  output logic [7:0]                           o_retry_total,
  output logic [3:0]                           o_state
`endif
);

  localparam int unsigned CW       = idx_w(TOTAL_CHNL_NUM);
  localparam int unsigned RW       = idx_w(MAX_RETRY + 1);
  localparam int unsigned TMAX     = (TIMEOUT_CYC > RST_SETTLE_CYC) ? TIMEOUT_CYC : RST_SETTLE_CYC;
  localparam int unsigned TNEED    = $clog2(TMAX + 1);
  localparam int unsigned TW       = (TNEED > TMR_W) ? TNEED : TMR_W;
  localparam int unsigned LAST_IDX = (ACTIVE_CHNL_NUM == 0) ? 0 : ACTIVE_CHNL_NUM - 1;
  localparam logic [TOTAL_CHNL_NUM-1:0] ACT_MASK = (ACTIVE_CHNL_NUM == 0) ? '0 :
    ({TOTAL_CHNL_NUM{1'b1}} >> (TOTAL_CHNL_NUM - ACTIVE_CHNL_NUM));

  bringup_state_e state_q, state_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [TOTAL_CHNL_NUM-1:0] rstn_q, rstn_d, txr_q, txr_d, rxr_q, rxr_d, mac_q, mac_d;
  logic lost_q, lost_d, start_q, entry_q;
  logic start_rise, start_acc, timeout_hit, tmr_expired;
  logic [TW-1:0] tmr_val;

  assign start_rise = i_start & ~start_q;

  // Timer loads on the first cycle of each state, so every entry (including retries) reloads it.
  always_comb begin
    tmr_val = '0;
    case (state_q)
      ST_RST_REL:                      tmr_val = TW'(RST_SETTLE_CYC);
      ST_TX_LOCK, ST_RX_LOCK, ST_ALIGN: tmr_val = TW'(TIMEOUT_CYC);
      default:                         tmr_val = '0;
    endcase
  end

  aib_bringup_timer #(.W(TW)) u_timer (
    .i_clk     (i_osc_clk),
    .i_rst     (i_rst),
    .i_load    (entry_q),
    .i_value   (tmr_val),
    .o_expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    retry_d     = retry_q;
    rstn_d      = rstn_q;
    txr_d       = txr_q;
    rxr_d       = rxr_q;
    mac_d       = mac_q;
    lost_d      = lost_q;
    start_acc   = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      ST_IDLE:      start_acc = start_rise;
      ST_WAIT_CONF: if (i_conf_done) begin
        ptr_d   = '0;
        state_d = (ACTIVE_CHNL_NUM == 0) ? ST_DONE : ST_RST_REL;
      end
      ST_RST_REL: begin
        rstn_d[ptr_q] = 1'b1;
        if (tmr_expired) state_d = ST_TX_LOCK;
      end
      ST_TX_LOCK: begin
        txr_d[ptr_q] = 1'b1;
        if (i_tx_transfer_en[ptr_q]) state_d = ST_RX_LOCK;
        else                         timeout_hit = tmr_expired;
      end
      ST_RX_LOCK: begin
        txr_d[ptr_q] = 1'b1;
        rxr_d[ptr_q] = 1'b1;
        if (i_rx_transfer_en[ptr_q]) state_d = ST_ALIGN;
        else                         timeout_hit = tmr_expired;
      end
      ST_ALIGN: begin
        if (i_rx_align_done[ptr_q]) begin
          mac_d[ptr_q] = 1'b1;
          state_d      = ST_NEXT;
        end else begin
          timeout_hit = tmr_expired;
        end
      end
      ST_NEXT: begin
        retry_d = '0;
        if (ptr_q == CW'(LAST_IDX)) begin
          state_d = ST_DONE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = ST_RST_REL;
        end
      end
      ST_DONE: begin
        mac_d     = mac_q & i_tx_transfer_en & i_rx_transfer_en;
        lost_d    = lost_q | (|(mac_q & ~(i_tx_transfer_en & i_rx_transfer_en)));
        start_acc = start_rise;
      end
      ST_FAIL:  start_acc = start_rise;
      default:  state_d   = ST_IDLE;
    endcase

    // Reset release in RST_REL happens one cycle after entry, giving the single-cycle rstn pulse.
    if (timeout_hit) begin
      txr_d[ptr_q]  = 1'b0;
      rxr_d[ptr_q]  = 1'b0;
      rstn_d[ptr_q] = 1'b0;
      if (retry_q == RW'(MAX_RETRY)) begin
        state_d = ST_FAIL;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = ST_RST_REL;
      end
    end

    if (start_acc || i_por) begin
      state_d = i_por ? ST_IDLE : ST_WAIT_CONF;
      ptr_d   = '0;
      retry_d = '0;
      rstn_d  = '0;
      txr_d   = '0;
      rxr_d   = '0;
      mac_d   = '0;
      lost_d  = 1'b0;
    end

    rstn_d = rstn_d & ACT_MASK;
    txr_d  = txr_d & ACT_MASK;
    rxr_d  = rxr_d & ACT_MASK;
    mac_d  = mac_d & ACT_MASK;
  end

  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      retry_q <= '0;
      rstn_q  <= '0;
      txr_q   <= '0;
      rxr_q   <= '0;
      mac_q   <= '0;
      lost_q  <= 1'b0;
      start_q <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      retry_q <= retry_d;
      rstn_q  <= rstn_d;
      txr_q   <= txr_d;
      rxr_q   <= rxr_d;
      mac_q   <= mac_d;
      lost_q  <= lost_d;
      start_q <= i_start;
      entry_q <= (state_d != state_q);
    end
  end

  assign o_ns_adapter_rstn = rstn_q;
  assign o_tx_lock_req     = txr_q;
  assign o_rx_lock_req     = rxr_q;
  assign o_ns_mac_rdy      = mac_q;
  assign o_busy            = state_q inside {ST_WAIT_CONF, ST_RST_REL, ST_TX_LOCK,
                                             ST_RX_LOCK, ST_ALIGN, ST_NEXT};
  assign o_done            = (state_q == ST_DONE);
  assign o_fail            = (state_q == ST_FAIL);
  assign o_fail_chnl       = (state_q == ST_FAIL) ? ptr_q : '0;
  assign o_link_lost       = lost_q;

`ifdef AIB_BRINGUP_DBG_EN
  logic [7:0] rtot_q, rtot_d;

  always_comb begin
    rtot_d = rtot_q;
    if (i_por || start_acc)                   rtot_d = '0;
    else if (timeout_hit && rtot_q != 8'hFF)  rtot_d = rtot_q + 1'b1;
  end

  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) rtot_q <= '0;
    else       rtot_q <= rtot_d;
  end

  assign o_retry_total = rtot_q;
  assign o_state       = state_q;
`endif

endmodule

// File: tb/tb_aib_chnl_bringup_seq.sv
// Randomized bring-up bench: a channel responder with per-attempt failure profiles plus a
// whole-run outcome model (which channels come up, who fails, how many resets each sees).
module tb_aib_chnl_bringup_seq;

  localparam int unsigned TOT    = 8;
  localparam int unsigned ACT    = 6;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 64;
  localparam int unsigned MAXR   = 3;

  logic clk = 1'b0;
  logic rst, start, conf, por, clr_req;
  logic [TOT-1:0] tx_r, rx_r, al_r, drop_tx, drop_rx, prev;
  logic [TOT-1:0] tx_en, rx_en;
  logic [TOT-1:0] rstn_w, txreq_w, rxreq_w, mac_w;
  logic busy_w, done_w, fail_w, lost_w;
  logic [2:0] fchnl_w;
`ifdef AIB_BRINGUP_DBG_EN
  logic [7:0] rtot_w;
  logic [3:0] state_w;
`endif

  assign tx_en = tx_r & ~drop_tx;
  assign rx_en = rx_r & ~drop_rx;

  always #5 clk = ~clk;

  aib_chnl_bringup_seq #(
    .TOTAL_CHNL_NUM  (TOT),
    .ACTIVE_CHNL_NUM (ACT),
    .RST_SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC     (TMO),
    .MAX_RETRY       (MAXR)
  ) dut (
    .i_osc_clk         (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_conf_done       (conf),
    .i_por             (por),
    .o_ns_adapter_rstn (rstn_w),
    .o_tx_lock_req     (txreq_w),
    .o_rx_lock_req     (rxreq_w),
    .i_tx_transfer_en  (tx_en),
    .i_rx_transfer_en  (rx_en),
    .i_rx_align_done   (al_r),
    .o_ns_mac_rdy      (mac_w),
    .o_busy            (busy_w),
    .o_done            (done_w),
    .o_fail            (fail_w),
    .o_fail_chnl       (fchnl_w),
    .o_link_lost       (lost_w)
`ifdef AIB_BRINGUP_DBG_EN
    ,
    .o_retry_total     (rtot_w),
    .o_state           (state_w)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-channel profile: attempts that fail before success, which phase stalls, latencies.
  int unsigned nfail [TOT];
  int unsigned ph    [TOT];
  int unsigned lat_t [TOT];
  int unsigned lat_r [TOT];
  int unsigned lat_a [TOT];

  // Responder/monitor state, written only by the responder process.
  int unsigned falls [TOT];
  int unsigned maxlow[TOT];
  int unsigned lowcnt[TOT];
  int unsigned tc[TOT], rc[TOT], ac[TOT];
  int unsigned order_bad;

  initial begin
    bit fail_now;
    tx_r = '0; rx_r = '0; al_r = '0; prev = '0; order_bad = 0;
    for (int c = 0; c < TOT; c++) begin
      falls[c] = 0; maxlow[c] = 0; lowcnt[c] = 0; tc[c] = 0; rc[c] = 0; ac[c] = 0;
    end
    forever begin
      @(negedge clk);
      if (clr_req) order_bad = 0;
      for (int c = 0; c < TOT; c++) begin
        if (clr_req) begin
          falls[c] = 0; maxlow[c] = 0; lowcnt[c] = 0;
        end
        if (!rstn_w[c]) begin
          if (prev[c]) begin
            falls[c]++;
            lowcnt[c] = 0;
          end
          lowcnt[c]++;
          tx_r[c] = 1'b0; rx_r[c] = 1'b0; al_r[c] = 1'b0;
          tc[c] = 0; rc[c] = 0; ac[c] = 0;
        end else begin
          if (!prev[c]) begin
            if (falls[c] > 0 && lowcnt[c] > maxlow[c]) maxlow[c] = lowcnt[c];
            if (c > 0) begin
              if (!mac_w[c-1]) order_bad++;
            end
          end
          lowcnt[c] = 0;
          fail_now = (falls[c] < nfail[c]);
          if (txreq_w[c] && !tx_r[c]) begin
            tc[c]++;
            if (tc[c] >= lat_t[c] && !(fail_now && ph[c] == 0)) tx_r[c] = 1'b1;
          end
          if (rxreq_w[c] && !rx_r[c]) begin
            rc[c]++;
            if (rc[c] >= lat_r[c] && !(fail_now && ph[c] == 1)) rx_r[c] = 1'b1;
          end
          if (rx_r[c] && !al_r[c]) begin
            ac[c]++;
            if (ac[c] >= lat_a[c] && !(fail_now && ph[c] == 2)) al_r[c] = 1'b1;
          end
        end
        prev[c] = rstn_w[c];
      end
    end
  end

  task automatic set_profile_clean();
    for (int c = 0; c < TOT; c++) begin
      nfail[c] = 0;
      ph[c]    = $urandom_range(2, 0);
      lat_t[c] = $urandom_range(20, 1);
      lat_r[c] = $urandom_range(20, 1);
      lat_a[c] = $urandom_range(20, 1);
    end
  endtask

  task automatic kick_start();
    conf = 1'b0; drop_tx = '0; drop_rx = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("start_busy", busy_w, 1);
    check_eq("start_clear_mac", mac_w, 0);
    check_eq("start_clear_rstn", rstn_w, 0);
    check_eq("start_clear_flags", {done_w, fail_w, lost_w}, 0);
    clr_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic run_scenario(input int unsigned conf_delay);
    logic [TOT-1:0] em, em2;
    bit exp_fail;
    int unsigned fidx, tot_to, ef, n, d;
    kick_start();
    repeat (conf_delay) @(negedge clk);
    check_eq("conf_hold_busy", busy_w, 1);
    check_eq("conf_hold_rstn", rstn_w, 0);
    conf = 1'b1;
    n = 0;
    while (!(done_w || fail_w) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("end_reached", done_w | fail_w, 1);

    exp_fail = 0; fidx = 0; tot_to = 0; em = '0;
    for (int c = 0; c < ACT; c++) begin
      if (!exp_fail) begin
        if (nfail[c] > MAXR) begin
          exp_fail = 1; fidx = c; tot_to += MAXR + 1;
        end else begin
          em[c] = 1'b1; tot_to += nfail[c];
        end
      end
    end
    check_eq("done", done_w, !exp_fail);
    check_eq("fail", fail_w, exp_fail);
    check_eq("fail_chnl", fchnl_w, exp_fail ? fidx : 0);
    check_eq("mac_rdy", mac_w, em);
    check_eq("rstn", rstn_w, em);
    check_eq("tx_req", txreq_w, em);
    check_eq("rx_req", rxreq_w, em);
    check_eq("busy_end", busy_w, 0);
    check_eq("link_lost_end", lost_w, 0);
    check_eq("order", order_bad, 0);
    for (int c = 0; c < ACT; c++) begin
      if (exp_fail && c == fidx)     ef = MAXR + 1;
      else if (exp_fail && c > fidx) ef = 0;
      else                           ef = nfail[c];
      check_eq($sformatf("rstn_falls[%0d]", c), falls[c], ef);
      if (ef > 0 && !(exp_fail && c == fidx && MAXR == 0))
        check_eq($sformatf("rstn_pulse_w[%0d]", c), maxlow[c], 1);
    end
`ifdef AIB_BRINGUP_DBG_EN
    check_eq("retry_total", rtot_w, (tot_to > 255) ? 255 : tot_to);
`endif
    if (!exp_fail) begin
      d = $urandom_range(ACT - 1, 0);
      if ($urandom_range(1, 0) == 1) drop_tx[d] = 1'b1;
      else                           drop_rx[d] = 1'b1;
      repeat (3) @(negedge clk);
      em2 = em; em2[d] = 1'b0;
      check_eq("drop_mac", mac_w, em2);
      check_eq("drop_lost", lost_w, 1);
      check_eq("drop_done", done_w, 1);
    end
  endtask

  task automatic por_test();
    int unsigned n;
    set_profile_clean();
    kick_start();
    conf = 1'b1;
    n = 0;
    while (!rxreq_w[3] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("por_reach_rx3", rxreq_w[3], 1);
    check_eq("por_mac_before", mac_w, 8'h07);
    por = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check_eq("por_rstn", rstn_w, 0);
    check_eq("por_req", {txreq_w, rxreq_w}, 0);
    check_eq("por_mac", mac_w, 0);
    check_eq("por_flags", {busy_w, done_w, fail_w, lost_w}, 0);
`ifdef AIB_BRINGUP_DBG_EN
    check_eq("por_state", state_w, 0);
`endif
    @(negedge clk); por = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("por_start_ignored", busy_w, 0);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; conf = 1'b0; por = 1'b0; clr_req = 1'b0;
    drop_tx = '0; drop_rx = '0;
    set_profile_clean();
    repeat (3) @(negedge clk);
    check_eq("rst_rstn", rstn_w, 0);
    check_eq("rst_req", {txreq_w, rxreq_w}, 0);
    check_eq("rst_mac", mac_w, 0);
    check_eq("rst_flags", {busy_w, done_w, fail_w, lost_w}, 0);
    check_eq("rst_fail_chnl", fchnl_w, 0);
`ifdef AIB_BRINGUP_DBG_EN
    check_eq("rst_retry_total", rtot_w, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_no_start", busy_w, 0);

    set_profile_clean();
    run_scenario(10000);

    set_profile_clean();
    nfail[0] = 1;
    run_scenario(5);

    set_profile_clean();
    nfail[1] = 4; ph[1] = 0;
    run_scenario(3);

    por_test();
    set_profile_clean();
    run_scenario(2);

    for (int s = 0; s < 6; s++) begin
      set_profile_clean();
      for (int c = 0; c < ACT; c++) begin
        n_pick(c);
      end
      run_scenario($urandom_range(20, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic n_pick(input int c);
    int unsigned r;
    r = $urandom_range(99, 0);
    if (r < 70)      nfail[c] = 0;
    else if (r < 90) nfail[c] = $urandom_range(MAXR, 1);
    else             nfail[c] = MAXR + 1;
  endtask

endmodule

// File: doc/aib_chnl_bringup_seq.md
Name: aib_chnl_bringup_seq

Overview:
Serial link bring-up sequencer for the multi-channel AIB PHY top. It drives each active channel's adapter reset, DCC/DLL lock requests and MAC-ready. It then waits for transfer-enable and alignment status before moving to the next channel. Channels come up one at a time to bound inrush and calibration activity; bounded timeouts with retry apply. Sits beside the PHY top in the same clock domain as the oscillator clock.

Parameters:
TOTAL_CHNL_NUM, 24, number of channel slots
ACTIVE_CHNL_NUM, 24, channels [0..ACTIVE_CHNL_NUM-1] are sequenced; others skipped, outputs held 0
RST_SETTLE_CYC, 16, cycles after adapter reset release before lock requests
TIMEOUT_CYC, 4096, max cycles per wait phase (TX lock, RX lock, align)
MAX_RETRY, 3, retries per channel before failure

Ports:
i_osc_clk  in  1  sequencer clock
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  level; rising edge in IDLE starts bring-up
i_conf_done  in  1  config complete; sequencing waits for 1
i_por  in  1  power-on reset active; synchronous abort to IDLE
o_ns_adapter_rstn  out  TOTAL_CHNL_NUM  per-channel adapter reset, active low
o_tx_lock_req  out  TOTAL_CHNL_NUM  TX DCC/DLL lock request
o_rx_lock_req  out  TOTAL_CHNL_NUM  RX DCC/DLL lock request
i_tx_transfer_en  in  TOTAL_CHNL_NUM  TX calibrated
i_rx_transfer_en  in  TOTAL_CHNL_NUM  RX calibrated
i_rx_align_done  in  TOTAL_CHNL_NUM  word alignment done
o_ns_mac_rdy  out  TOTAL_CHNL_NUM  channel up, MAC may run
o_busy  out  1  sequencing in progress
o_done  out  1  all active channels up
o_fail  out  1  sticky failure
o_fail_chnl  out  $clog2(TOTAL_CHNL_NUM)  failing channel index
o_link_lost  out  1  sticky: up channel dropped transfer_en

Behaviour:
- Reset values: all per-channel outputs 0 (adapter reset asserted). o_busy, o_done, o_fail, o_link_lost 0. o_fail_chnl 0. State IDLE, channel pointer 0, retry count 0.
- States: IDLE, WAIT_CONF, RST_REL, TX_LOCK, RX_LOCK, ALIGN, NEXT, DONE, FAIL.
- IDLE: a rising i_start, registered edge-detect, moves to WAIT_CONF. o_busy goes 1 the next cycle.
- WAIT_CONF: stays until i_conf_done=1, with no timeout. Then moves to RST_REL with pointer 0.
- RST_REL: sets o_ns_adapter_rstn[ptr]=1 and loads the timer with RST_SETTLE_CYC. On expiry, moves to TX_LOCK.
- TX_LOCK: sets o_tx_lock_req[ptr]=1 and loads TIMEOUT_CYC. i_tx_transfer_en[ptr]=1 moves to RX_LOCK.
- RX_LOCK: o_tx_lock_req[ptr] stays 1 and o_rx_lock_req[ptr] is set to 1. i_rx_transfer_en[ptr] moves to ALIGN.
- ALIGN: waits for i_rx_align_done[ptr]. When it arrives, o_ns_mac_rdy[ptr]=1 and the state moves to NEXT.
- Timer reload: the timer reloads on every state entry.
- Timeout (TX_LOCK, RX_LOCK or ALIGN):
  - Clear lock reqs[ptr] and drive o_ns_adapter_rstn[ptr]=0 for one cycle.
  - Increment retry and re-enter RST_REL.
  - If retry==MAX_RETRY at timeout, go to FAIL instead.
- Simultaneous expiry and success in the same cycle: success wins.
- NEXT: clears retry and increments the pointer.
  - If ptr==ACTIVE_CHNL_NUM-1, go to DONE; otherwise go to RST_REL.
  - Pointer never wraps.
- ACTIVE_CHNL_NUM=0: go directly WAIT_CONF -> DONE.
- DONE: o_done=1, o_busy=0, and all earlier outputs are held.
  - If any up channel sees i_tx_transfer_en or i_rx_transfer_en fall, clear its o_ns_mac_rdy and set o_link_lost (sticky).
  - There is no automatic re-bring-up.
- FAIL: o_fail=1 and o_fail_chnl=ptr. The failed channel is held in adapter reset; earlier channels stay up.
- Leaving DONE/FAIL: a new rising i_start clears o_done, o_fail and o_link_lost, all per-channel outputs return to reset values, and the state moves to WAIT_CONF.
- i_por=1 in any state: next cycle, all outputs return to reset values and the state goes to IDLE. i_start is ignored while i_por=1.
- i_conf_done dropping after WAIT_CONF is ignored.
- Channels ≥ACTIVE_CHNL_NUM: outputs are constant 0.

Optional Feature:
AIB_BRINGUP_DBG_EN
- Defined: adds o_retry_total[7:0], a saturating count of all timeouts since the last start, and o_state[3:0], the encoded current state.
- Undefined: neither port exists and the counter is not built; functional behaviour is identical.

Decomposition:
- Package aib_bringup_pkg: state enum with fixed 4-bit encodings, a timer-width constant of $clog2(TIMEOUT_CYC+1), and a channel-index width function.
- Sub-module aib_bringup_timer: loadable down-counter with load and value inputs, and an expired flag that is 1 when the count is 0 with no load pending.

Test Plan:
- ACTIVE=2, model answers each req after 10 cycles -> channel 0 fully up before channel 1 rstn rises; o_done=1, o_ns_mac_rdy=2'b11, o_fail=0.
- Channel 1 never asserts tx_transfer_en, TIMEOUT_CYC=64, MAX_RETRY=3 -> four attempts, each with a 1-cycle rstn=0 pulse; o_fail=1, o_fail_chnl=1, mac_rdy[0]=1.
- Channel 0 succeeds on its 2nd attempt -> no failure, retry count cleared at NEXT; with DBG, o_retry_total=1.
- i_por pulses during RX_LOCK of channel 3 -> next cycle all outputs are 0 and the state is IDLE; re-assert i_start -> restarts from channel 0.
- After DONE, drop i_rx_transfer_en[0] -> o_ns_mac_rdy[0]=0 and o_link_lost=1; other channels are unchanged.
- i_conf_done held 0 for 10000 cycles after start -> stays in WAIT_CONF, o_busy=1, no timeout.
